// File: rtl/gcd_controller.sv
// Sequencing FSM for the GCD datapath: Euclid's algorithm by repeated modulo,
// with start/busy/done/err handshake and an iteration timeout.
module gcd_controller #(
    parameter int unsigned ALU_LATENCY = 1,
    parameter int unsigned MAX_ITER    = 32,
    parameter logic [2:0]  ALU_NOP     = 3'b000,
    parameter logic [2:0]  ALU_CMP     = 3'b001,
    parameter logic [2:0]  ALU_MOD     = 3'b010
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic       gross_zero_i,
    input  logic       klein_zero_i,
    input  logic       erg_zero_i,
    output logic [2:0] alu_mode_o,
    output logic       Zahl1_to_alu_a_o,
    output logic       Zahl2_to_alu_b_o,
    output logic       erg_modulo_to_alu_a_o,
    output logic       wren_zw_in_zahlen_o,
    output logic       wren_zw_gross_o,
    output logic       wren_zw_klein_o,
    output logic       wren_erg_modulo_o,
    output logic       wren_to_new_numbers_o,
    output logic       check_for_termination_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o,
    output logic [7:0] iter_cnt_o
);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_CMP, S_ORDER, S_ZCHK, S_MOD,
        S_MWB, S_CHK, S_SHIFT, S_DONE, S_ERR
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(ALU_LATENCY - 1);
    localparam logic [7:0] ITER_MAX  = 8'(MAX_ITER);

    state_t     state_q, state_d;
    logic [3:0] wait_q, wait_d;
    logic [7:0] iter_q, iter_d;

    // NOTE: state flops take non-blocking assignments only; all decisions live in the comb blocks.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            iter_q  <= iter_d;
        end
    end

    // NOTE: every comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        iter_d  = iter_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_LOAD;
                    iter_d  = '0;
                end
            end
            S_LOAD: begin
                state_d = S_CMP;
                wait_d  = '0;
            end
            S_CMP: begin
                if (wait_q == WAIT_LAST) begin
                    state_d = S_ORDER;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            S_ORDER: state_d = S_ZCHK;
            S_ZCHK: begin
                if (gross_zero_i && klein_zero_i) state_d = S_ERR;
                else if (klein_zero_i)            state_d = S_DONE;
                else                              state_d = S_MOD;
            end
            S_MOD: begin
                if (wait_q == WAIT_LAST) begin
                    state_d = S_MWB;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            S_MWB: begin
                state_d = S_CHK;
                iter_d  = (iter_q == 8'hFF) ? iter_q : iter_q + 8'd1;
            end
            S_CHK: begin
                if (erg_zero_i)              state_d = S_DONE;
                else if (iter_q == ITER_MAX) state_d = S_ERR;
                else                         state_d = S_SHIFT;
            end
            S_SHIFT: state_d = S_MOD;
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Moore outputs, decoded from the registered state only.
    always_comb begin
        alu_mode_o              = ALU_NOP;
        Zahl1_to_alu_a_o        = 1'b0;
        Zahl2_to_alu_b_o        = 1'b0;
        erg_modulo_to_alu_a_o   = 1'b0;
        wren_zw_in_zahlen_o     = 1'b0;
        wren_zw_gross_o         = 1'b0;
        wren_zw_klein_o         = 1'b0;
        wren_erg_modulo_o       = 1'b0;
        wren_to_new_numbers_o   = 1'b0;
        check_for_termination_o = 1'b0;
        busy_o                  = (state_q != S_IDLE);
        done_o                  = 1'b0;
        err_o                   = 1'b0;
        iter_cnt_o              = iter_q;
        unique case (state_q)
            S_LOAD:  wren_zw_in_zahlen_o = 1'b1;
            S_CMP: begin
                alu_mode_o       = ALU_CMP;
                Zahl1_to_alu_a_o = 1'b1;
                Zahl2_to_alu_b_o = 1'b1;
            end
            S_ORDER: begin
                alu_mode_o      = ALU_CMP;
                wren_zw_gross_o = 1'b1;
                wren_zw_klein_o = 1'b1;
            end
            S_MOD:   alu_mode_o = ALU_MOD;
            S_MWB: begin
                alu_mode_o        = ALU_MOD;
                wren_erg_modulo_o = 1'b1;
            end
            S_CHK:   check_for_termination_o = 1'b1;
            S_SHIFT: wren_to_new_numbers_o   = 1'b1;
            S_DONE:  done_o = 1'b1;
            S_ERR:   err_o  = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_gcd_controller.sv
// Bench for gcd_controller: three parameter sets share operands, each with its
// own datapath stand-in, scoreboard queue and monitor against a Euclid reference model.
module tb_gcd_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] z1, z2;
    logic       start  [3];
    logic       busy_w [3];
    logic [22:0] outs_w [3];

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit is_err;
        bit z_exit;
        int cycle;
        int iter;
        int result;
        int shifts;
        int mod_cycles;
    } exp_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Euclid by plain arithmetic; timing from the state-sequence latency rules.
    function automatic exp_t ref_model(input int a0, input int b0, input int lat, input int max_it);
        exp_t e;
        int a, b, r, k;
        bit fin;
        a = (a0 >= b0) ? a0 : b0;
        b = (a0 >= b0) ? b0 : a0;
        e = '{default: 0};
        if (b == 0) begin
            e.is_err = (a == 0);
            e.z_exit = 1'b1;
            e.result = a;
            e.cycle  = lat + 4;
        end else begin
            k = 0;
            fin = 1'b0;
            while (!fin) begin
                r = a % b;
                k++;
                if (r == 0) begin
                    e.result = b;
                    fin = 1'b1;
                end else if (k == max_it) begin
                    e.is_err = 1'b1;
                    fin = 1'b1;
                end else begin
                    a = b;
                    b = r;
                end
            end
            e.iter       = k;
            e.shifts     = k - 1;
            e.mod_cycles = k * lat;
            e.cycle      = lat + 4 + k * (lat + 2) + (k - 1);
        end
        return e;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : inst
        localparam int L = (g == 2) ? 3 : 1;
        localparam int M = (g == 1) ? 2 : 32;

        logic [2:0] alu_mode;
        logic z1a, z2b, erga, w_in, w_g, w_k, w_e, w_new, chk, busy, done, err;
        logic [7:0] iter;
        logic [7:0] za = '0, zb = '0, gross = '0, klein = '0, erg = '0;

        gcd_controller #(.ALU_LATENCY(L), .MAX_ITER(M)) dut (
            .clk                    (clk),
            .rst                    (rst),
            .start_i                (start[g]),
            .gross_zero_i           (gross == 8'd0),
            .klein_zero_i           (klein == 8'd0),
            .erg_zero_i             (erg == 8'd0),
            .alu_mode_o             (alu_mode),
            .Zahl1_to_alu_a_o       (z1a),
            .Zahl2_to_alu_b_o       (z2b),
            .erg_modulo_to_alu_a_o  (erga),
            .wren_zw_in_zahlen_o    (w_in),
            .wren_zw_gross_o        (w_g),
            .wren_zw_klein_o        (w_k),
            .wren_erg_modulo_o      (w_e),
            .wren_to_new_numbers_o  (w_new),
            .check_for_termination_o(chk),
            .busy_o                 (busy),
            .done_o                 (done),
            .err_o                  (err),
            .iter_cnt_o             (iter)
        );

        assign busy_w[g] = busy;
        assign outs_w[g] = {alu_mode, z1a, z2b, erga, w_in, w_g, w_k, w_e, w_new,
                            chk, busy, done, err, iter};

        // Datapath stand-in driven by the controller's enables.
        always @(posedge clk) begin
            if (w_in) begin
                za <= z1;
                zb <= z2;
            end
            if (w_g && w_k) begin
                gross <= (za >= zb) ? za : zb;
                klein <= (za >= zb) ? zb : za;
            end
            if (w_e && klein != 8'd0) erg <= gross % klein;
            if (w_new) begin
                gross <= klein;
                klein <= erg;
            end
        end

        exp_t q[$];

        always @(posedge clk) begin
            if (rst) q.delete();
            else if (start[g] && !busy) q.push_back(ref_model(int'(z1), int'(z2), L, M));
        end

        int cyc = 0, shifts = 0, mods = 0, hold_val = 0;
        bit hold_pending = 1'b0;
        exp_t e;

        always @(negedge clk) begin
            if (hold_pending) begin
                hold_pending = 1'b0;
                if (!rst) check($sformatf("i%0d iter_hold", g), int'(iter), hold_val);
            end
            if (rst || !busy) begin
                cyc = 0; shifts = 0; mods = 0;
            end else begin
                cyc++;
                if (w_new) shifts++;
                if (alu_mode == 3'b010 && !w_e) mods++;
                if (done || err) begin
                    if (q.size() == 0) begin
                        check($sformatf("i%0d unexpected_end", g), 1, 0);
                    end else begin
                        e = q.pop_front();
                        check($sformatf("i%0d both_flags", g), int'(done && err), 0);
                        check($sformatf("i%0d err_kind", g), int'(err), int'(e.is_err));
                        check($sformatf("i%0d end_cycle", g), cyc, e.cycle);
                        check($sformatf("i%0d iter_cnt", g), int'(iter), e.iter);
                        check($sformatf("i%0d shift_pulses", g), shifts, e.shifts);
                        check($sformatf("i%0d mod_cycles", g), mods, e.mod_cycles);
                        if (!e.is_err)
                            check($sformatf("i%0d result", g),
                                  int'(e.z_exit ? gross : klein), e.result);
                        hold_val     = e.iter;
                        hold_pending = 1'b1;
                    end
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        for (int g = 0; g < 3; g++)
            check($sformatf("%s_outs_i%0d", tag, g), int'(outs_w[g]), 0);
    endtask

    task automatic run_txn(input logic [7:0] a, input logic [7:0] b);
        bit all_idle;
        int budget;
        @(negedge clk);
        z1 = a;
        z2 = b;
        for (int g = 0; g < 3; g++) start[g] = 1'b1;
        @(negedge clk);
        for (int g = 0; g < 3; g++) start[g] = 1'b0;
        all_idle = 1'b0;
        budget   = 0;
        while (!all_idle && budget < 2000) begin
            @(negedge clk);
            budget++;
            all_idle = 1'b1;
            for (int g = 0; g < 3; g++) begin
                if (busy_w[g]) all_idle = 1'b0;
                start[g] = busy_w[g] && ($urandom_range(0, 3) == 0);
            end
        end
        for (int g = 0; g < 3; g++) start[g] = 1'b0;
        if (!all_idle) check("txn_timeout", 1, 0);
    endtask

    logic [7:0] dir_a [6] = '{8'd48, 8'd0, 8'd0, 8'd21, 8'd18, 8'd255};
    logic [7:0] dir_b [6] = '{8'd18, 8'd7, 8'd0, 8'd7, 8'd48, 8'd1};

    initial begin
        rst = 1'b1;
        z1  = '0;
        z2  = '0;
        for (int g = 0; g < 3; g++) start[g] = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_txn(dir_a[i], dir_b[i]);

        // Reset in the middle of a run must return every instance to idle.
        @(negedge clk);
        z1 = 8'd89;
        z2 = 8'd55;
        for (int g = 0; g < 3; g++) start[g] = 1'b1;
        @(negedge clk);
        for (int g = 0; g < 3; g++) start[g] = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("midrst");
        rst = 1'b0;

        for (int i = 0; i < 30; i++) begin
            logic [7:0] a, b;
            a = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            run_txn(a, b);
        end

        repeat (3) @(negedge clk);
        check("pending_i0", inst[0].q.size(), 0);
        check("pending_i1", inst[1].q.size(), 0);
        check("pending_i2", inst[2].q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
